swlight_multi: RTL
==================

Name: swlight_multi

Overview:
Parametrised successor to the single switch/light register block. It provides NREG Unibus switch/light register pairs at consecutive word addresses from BASEADDR. The ARM side can read and write everything. It also adds a halt/single-step bus-request state machine that the ARM processor controls. It sits on the ARM register bus and the Unibus pin interface, in parallel with the other zynq Unibus devices.

Parameters:
NREG, 2, number of switch/light pairs (1..4)
BASEADDR, 18'o777570, Unibus byte address of pair 0 (must be even)
VERSION, 12'h001, version field in ARM ID register

Ports:
CLOCK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
armwrite  input  1  ARM write strobe, one cycle
armraddr  input  3  ARM read register index
armwaddr  input  3  ARM write register index
armwdata  input  32  ARM write data
armrdata  output  32  ARM read data, combinational from armraddr
a_in_h  input  18  Unibus address
c_in_h  input  2  Unibus C1,C0 (C1=1 write, C0=1 byte)
d_in_h  input  16  Unibus data in
hltgr_in_l  input  1  halt grant, active low
init_in_h  input  1  Unibus INIT
msyn_in_h  input  1  Unibus MSYN
d_out_h  output  16  Unibus data out
hltrq_out_h  output  1  halt request
init_out_h  output  1  drives Unibus INIT, equals businit
sack_out_h  output  1  selection acknowledge
ssyn_out_h  output  1  Unibus SSYN

Behaviour:
- Reset is asynchronous, active-high. All registers go to 0: lights, switches, enable, haltreq, stepreq, businit, halted, haltstate=IDLE, wrcnt, d_out_h, hltrq_out_h, sack_out_h, ssyn_out_h.
- ARM read map:
  - 0: {16'h534D, 4'(log2 NREG rounded up +1 -1), VERSION}. The [15:12] field is (log2 of register count) minus 1, where register count = 2+NREG rounded up to a power of two.
  - 1: {enable, haltreq, halted, stepreq, businit, haltstate[2:0], 8'b0, wrcnt[15:0]}.
  - 2+k, for k<NREG: {lights[k], switches[k]}.
  - Any other index: 32'hDEADBEEF.
- ARM writes:
  - Reg 1 loads enable=[31], haltreq=[30], stepreq=[28], businit=[27].
  - Reg 2+k loads switches[k]=[15:0]; lights are read-only from ARM.
  - Writes to other indices are ignored.
- INIT: init_in_h high clears d_out_h and ssyn_out_h only.
- Unibus slave behaviour:
  - An ARM write takes priority. In a cycle with armwrite=1, no Unibus action occurs; a pending Unibus cycle is serviced on the next clock.
  - msyn_in_h low: d_out_h=0 and ssyn_out_h=0 on the next clock.
  - Decode: enable=1, msyn_in_h high, ssyn_out_h=0, and a_in_h[17:1] == (BASEADDR>>1)+k for k<NREG. On a match, ssyn_out_h=1 on the next clock (one-cycle latency).
  - Write (C1=1): the high byte updates if C0=0 or a_in_h[0]=1. The low byte updates if C0=0 or a_in_h[0]=0.
  - Read (C1=0): d_out_h=switches[k].
  - ssyn_out_h stays high until msyn_in_h drops. No re-decode occurs while ssyn_out_h=1.
- Halt state machine (haltstate) advances only when enable=1:
  - IDLE(0): on haltreq, go to REQ and set hltrq_out_h=1.
  - REQ(1): on hltgr_in_l=0, go to GRANTED, set halted=1, hltrq_out_h=0, sack_out_h=1.
  - GRANTED(2): on hltgr_in_l=1, go to HELD.
  - HELD(3):
    - haltreq=0 has priority: go to IDLE, set halted=0, sack_out_h=0.
    - Otherwise, if stepreq=1: go to STEP, set sack_out_h=0, halted=0, stepreq=0.
  - STEP(4): one cycle, then go to REQ and set hltrq_out_h=1. The processor runs one instruction before it re-grants.
  - Codes 5-7 are illegal and go to IDLE.
- enable=0 on any clock forces haltstate=IDLE, hltrq_out_h=0, sack_out_h=0, halted=0. Register contents are kept.
- An ARM write of stepreq in the same cycle that the machine clears it: the ARM write wins.

Optional Feature:
SWLIGHT_MULTI_WRCNT_EN:
- Defined: wrcnt is a 16-bit counter. It increments once per decoded Unibus write to any lights register, at the clock that sets ssyn_out_h. It wraps 16'hFFFF to 0. An ARM write to reg 1 with armwdata[26]=1 clears it.
- Undefined: wrcnt reads as constant 0 and no counter logic exists.

Test Plan:
- Apply RESET mid-transfer, with ssyn_out_h=1 and haltstate=HELD -> all outputs 0 immediately, without waiting for a clock edge; reg 1 reads 0.
- Setup: NREG=2, enable=1, ARM writes reg 3 = 16'o012345. Unibus DATI at 777572 -> d_out_h=16'o012345 and SSYN one clock after MSYN. MSYN drop -> SSYN=0, d_out_h=0 on the next clock.
- DATOB to 777571 with d_in_h=16'hAB00 -> lights[0][15:8]=8'hAB, low byte unchanged. DATO to 777574 -> no SSYN (outside NREG=2).
- Same-cycle armwrite and Unibus DATI match -> SSYN delayed one clock; the data returned is the newly written switches value.
- Halt/step sequence:
  - haltreq=1, then hltgr_in_l low -> halted=1, sack=1.
  - hltgr_in_l high -> HELD.
  - stepreq=1 -> sack drops, stepreq reads 0, hltrq reasserts two clocks later.
  - haltreq=0 in HELD -> IDLE, halted=0.
- With SWLIGHT_MULTI_WRCNT_EN defined: 3 word writes plus 1 byte write -> wrcnt=4. Preloaded at 16'hFFFF, one write -> wrcnt=0.

Source files
------------

// File: rtl/swlight_multi.sv
// swlight_multi: NREG Unibus switch/light register pairs with ARM access and a halt/single-step
// bus-request machine. Optional Unibus write counter enabled by `define SWLIGHT_MULTI_WRCNT_EN.
module swlight_multi #(
  parameter int          NREG     = 2,
  parameter logic [17:0] BASEADDR = 18'o777570,
  parameter logic [11:0] VERSION  = 12'h001
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        hltgr_in_l,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        hltrq_out_h,
  output logic        init_out_h,
  output logic        sack_out_h,
  output logic        ssyn_out_h
);

  localparam logic [3:0]  SIZE_FIELD = 4'($clog2(2 + NREG) - 1);
  localparam logic [16:0] BASE_WORD  = BASEADDR[17:1];

  typedef enum logic [2:0] {
    HS_IDLE    = 3'd0,
    HS_REQ     = 3'd1,
    HS_GRANTED = 3'd2,
    HS_HELD    = 3'd3,
    HS_STEP    = 3'd4
  } halt_state_t;

  logic [15:0] lights   [NREG];
  logic [15:0] switches [NREG];
  logic        enable;
  logic        haltreq;
  logic        stepreq;
  logic        businit;
  logic        halted;
  logic [15:0] wrcnt;

  halt_state_t hs, hs_next;
  logic        halted_next;
  logic        hltrq_next;
  logic        sack_next;
  logic        step_clr;

  logic arm_ctrl_wr;
  assign arm_ctrl_wr = armwrite && (armwaddr == 3'd1);
  assign init_out_h  = businit;

  // ---------------------------------------------------------------------------
  // Unibus address decode
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] hit;
  logic [15:0]     hit_switches;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit          = '0;
    hit_switches = '0;
    for (int k = 0; k < NREG; k++) begin
      if (a_in_h[17:1] == BASE_WORD + 17'(k)) begin
        hit[k]       = 1'b1;
        hit_switches = switches[k];
      end
    end
  end

  logic uni_sel;
  logic uni_write;
  logic hi_en;
  logic lo_en;

  // An ARM write or INIT suppresses any Unibus action; a held MSYN is serviced afterwards.
  assign uni_sel   = ~init_in_h & ~armwrite & enable & msyn_in_h & ~ssyn_out_h & (|hit);
  assign uni_write = uni_sel & c_in_h[1];
  assign hi_en     = ~c_in_h[0] | a_in_h[0];
  assign lo_en     = ~c_in_h[0] | ~a_in_h[0];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      d_out_h    <= '0;
      ssyn_out_h <= 1'b0;
    end else if (init_in_h) begin
      d_out_h    <= '0;
      ssyn_out_h <= 1'b0;
    end else if (!armwrite) begin
      if (!msyn_in_h) begin
        d_out_h    <= '0;
        ssyn_out_h <= 1'b0;
      end else if (uni_sel) begin
        ssyn_out_h <= 1'b1;
        if (!c_in_h[1]) d_out_h <= hit_switches;
      end
    end
  end

  // NOTE: the register arrays are small and ARM-visible, so they are reset like any other flop.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NREG; k++) lights[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (uni_write && hit[k]) begin
          if (hi_en) lights[k][15:8] <= d_in_h[15:8];
          if (lo_en) lights[k][7:0]  <= d_in_h[7:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ARM-writable registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NREG; k++) switches[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (armwrite && armwaddr == 3'(k + 2)) switches[k] <= armwdata[15:0];
      end
    end
  end

  // The ARM write of stepreq wins over the machine clearing it in the same cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      enable  <= 1'b0;
      haltreq <= 1'b0;
      stepreq <= 1'b0;
      businit <= 1'b0;
    end else if (arm_ctrl_wr) begin
      enable  <= armwdata[31];
      haltreq <= armwdata[30];
      stepreq <= armwdata[28];
      businit <= armwdata[27];
    end else if (step_clr) begin
      stepreq <= 1'b0;
    end
  end

`ifdef SWLIGHT_MULTI_WRCNT_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wrcnt <= '0;
    end else if (arm_ctrl_wr && armwdata[26]) begin
      wrcnt <= '0;
    end else if (uni_write) begin
      wrcnt <= wrcnt + 16'd1;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{armwdata[29], armwdata[25:16]};
`else
  assign wrcnt = '0;

  logic unused_wdata;
  assign unused_wdata = ^{armwdata[29], armwdata[26:16]};
`endif

  // ---------------------------------------------------------------------------
  // Halt / single-step bus request machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hs          <= HS_IDLE;
      halted      <= 1'b0;
      hltrq_out_h <= 1'b0;
      sack_out_h  <= 1'b0;
    end else begin
      hs          <= hs_next;
      halted      <= halted_next;
      hltrq_out_h <= hltrq_next;
      sack_out_h  <= sack_next;
    end
  end

  always_comb begin
    hs_next     = hs;
    halted_next = halted;
    hltrq_next  = hltrq_out_h;
    sack_next   = sack_out_h;
    step_clr    = 1'b0;
    if (!enable) begin
      hs_next     = HS_IDLE;
      halted_next = 1'b0;
      hltrq_next  = 1'b0;
      sack_next   = 1'b0;
    end else begin
      case (hs)
        HS_IDLE: begin
          if (haltreq) begin
            hs_next    = HS_REQ;
            hltrq_next = 1'b1;
          end
        end
        HS_REQ: begin
          if (!hltgr_in_l) begin
            hs_next     = HS_GRANTED;
            halted_next = 1'b1;
            hltrq_next  = 1'b0;
            sack_next   = 1'b1;
          end
        end
        HS_GRANTED: begin
          if (hltgr_in_l) hs_next = HS_HELD;
        end
        HS_HELD: begin
          if (!haltreq) begin
            hs_next     = HS_IDLE;
            halted_next = 1'b0;
            sack_next   = 1'b0;
          end else if (stepreq) begin
            hs_next     = HS_STEP;
            halted_next = 1'b0;
            sack_next   = 1'b0;
            step_clr    = 1'b1;
          end
        end
        // The processor executes one instruction here before the request goes out again.
        HS_STEP: begin
          hs_next    = HS_REQ;
          hltrq_next = 1'b1;
        end
        default: hs_next = HS_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ARM read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    armrdata = 32'hDEADBEEF;
    case (armraddr)
      3'd0: armrdata = {16'h534D, SIZE_FIELD, VERSION};
      3'd1: armrdata = {enable, haltreq, halted, stepreq, businit, hs, 8'h00, wrcnt};
      default: begin
        for (int k = 0; k < NREG; k++) begin
          if (armraddr == 3'(k + 2)) armrdata = {lights[k], switches[k]};
        end
      end
    endcase
  end

endmodule
